// File: rtl/alu_seq_pkg.sv
// Shared opcodes, ALU mode encodings and FSM states for the ALU sequencer.
package alu_seq_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_ADC = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_INC = 3'b011;
   localparam logic [2:0] OP_DEC = 3'b100;
   localparam logic [2:0] OP_AND = 3'b101;
   localparam logic [2:0] OP_OR  = 3'b110;
   localparam logic [2:0] OP_XOR = 3'b111;

   localparam logic [2:0] MODE_ADD = 3'b000;
   localparam logic [2:0] MODE_SUB = 3'b010;
   localparam logic [2:0] MODE_AND = 3'b101;
   localparam logic [2:0] MODE_OR  = 3'b110;
   localparam logic [2:0] MODE_XOR = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_EXEC   = 3'd1,
      S_BUSREQ = 3'd2,
      S_DRIVE  = 3'd3,
      S_EXEC2  = 3'd4,
      S_DRIVE2 = 3'd5,
      S_RESP   = 3'd6
   } state_t;

   // INC/ADC are built on the adder and DEC on the subtractor.
   function automatic logic [2:0] op_to_mode(input logic [2:0] op);
      case (op)
         OP_ADD, OP_ADC, OP_INC: return MODE_ADD;
         OP_SUB, OP_DEC:         return MODE_SUB;
         OP_AND:                 return MODE_AND;
         OP_OR:                  return MODE_OR;
         OP_XOR:                 return MODE_XOR;
         default:                return MODE_ADD;
      endcase
   endfunction

   function automatic logic op_is_arith(input logic [2:0] op);
      return (op != OP_AND) && (op != OP_OR) && (op != OP_XOR);
   endfunction

   function automatic logic op_is_incdec(input logic [2:0] op);
      return (op == OP_INC) || (op == OP_DEC);
   endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU command sequencer: issues ALU ops, arbitrates for the shared
// bus, captures the result and maintains the architectural Z/C flags.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int GNT_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_mode,
   output logic              alu_ee,
   output logic              alu_eo,
   input  logic              alu_carry,
   input  logic [DATA_W-1:0] bus_in,
   output logic              bus_req,
   input  logic              bus_gnt,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic              res_err,
   output logic              flag_z,
   output logic              flag_c
);

   localparam logic [DATA_W-1:0] ONE  = DATA_W'(1);
   localparam logic [7:0]        TLIM = 8'(GNT_TIMEOUT - 1);

   state_t            state, state_next;
   logic [7:0]        cnt, cnt_next;
   logic [2:0]        op_r;
   logic              c1_r;
   logic              carry_now;

   logic              ee_n, eo_n, req_n, ready_n, valid_n;
   logic [DATA_W-1:0] a_n, b_n;
   logic [2:0]        mode_n;

   // Next-state logic and bus-grant wait counter.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         S_IDLE:   state_next = cmd_valid ? S_EXEC : S_IDLE;
         S_EXEC: begin
            state_next = S_BUSREQ;
            cnt_next   = 8'd0;
         end
         S_BUSREQ: begin
            if (bus_gnt) begin
               state_next = S_DRIVE;
            end else if (cnt == TLIM) begin
               state_next = S_RESP;
            end else begin
               cnt_next = cnt + 8'd1;
            end
         end
         S_DRIVE:  state_next = ((op_r == OP_ADC) && flag_c) ? S_EXEC2 : S_RESP;
         S_EXEC2:  state_next = S_DRIVE2;
         S_DRIVE2: state_next = S_RESP;
         S_RESP:   state_next = res_ready ? S_IDLE : S_RESP;
         default:  state_next = S_IDLE;
      endcase
   end

   // Second DRIVE of an ADC folds the +1 carry into the first add's carry.
   assign carry_now = (state == S_DRIVE2) ? (c1_r | alu_carry) : alu_carry;

   // Output values for the coming state, so every control line is a flop.
   always_comb begin
      ee_n    = 1'b0;
      eo_n    = 1'b0;
      req_n   = 1'b0;
      ready_n = 1'b0;
      valid_n = 1'b0;
      a_n     = '0;
      b_n     = '0;
      mode_n  = MODE_ADD;
      case (state_next)
         S_IDLE: ready_n = 1'b1;
         S_EXEC: begin
            ee_n   = 1'b1;
            a_n    = cmd_a;
            b_n    = op_is_incdec(cmd_op) ? ONE : cmd_b;
            mode_n = op_to_mode(cmd_op);
         end
         S_BUSREQ: req_n = 1'b1;
         S_DRIVE, S_DRIVE2: begin
            req_n = 1'b1;
            eo_n  = 1'b1;
         end
         S_EXEC2: begin
            req_n  = 1'b1;
            ee_n   = 1'b1;
            a_n    = bus_in;
            b_n    = ONE;
            mode_n = MODE_ADD;
         end
         S_RESP:  valid_n = 1'b1;
         default: ready_n = 1'b0;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Registered control/operand outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_ee    <= 1'b0;
         alu_eo    <= 1'b0;
         bus_req   <= 1'b0;
         cmd_ready <= 1'b0;
         res_valid <= 1'b0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_mode  <= MODE_ADD;
      end else begin
         alu_ee    <= ee_n;
         alu_eo    <= eo_n;
         bus_req   <= req_n;
         cmd_ready <= ready_n;
         res_valid <= valid_n;
         alu_a     <= a_n;
         alu_b     <= b_n;
         alu_mode  <= mode_n;
      end
   end

   // Command latch, result capture, error status and flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= 8'd0;
         op_r     <= OP_ADD;
         c1_r     <= 1'b0;
         res_data <= '0;
         res_err  <= 1'b0;
         flag_z   <= 1'b0;
         flag_c   <= 1'b0;
      end else begin
         cnt <= cnt_next;
         if ((state == S_IDLE) && cmd_valid) begin
            op_r    <= cmd_op;
            res_err <= 1'b0;
         end
         if ((state == S_BUSREQ) && (state_next == S_RESP)) begin
            res_data <= '0;
            res_err  <= 1'b1;
         end
         if ((state == S_DRIVE) || (state == S_DRIVE2)) begin
            res_data <= bus_in;
            c1_r     <= carry_now;
            if (state_next == S_RESP) begin
               flag_z <= (bus_in == '0);
               flag_c <= op_is_arith(op_r) & carry_now;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU and shared-bus model.
module tb_alu_sequencer;
   import alu_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_op = 3'b000;
   logic [7:0] cmd_a = 8'h00, cmd_b = 8'h00;
   logic [7:0] alu_a, alu_b;
   logic [2:0] alu_mode;
   logic       alu_ee, alu_eo, alu_carry;
   logic [7:0] bus_in;
   logic       bus_req, bus_gnt;
   logic       res_valid;
   logic       res_ready = 1'b1;
   logic [7:0] res_data;
   logic       res_err, flag_z, flag_c;
   logic       gnt_en = 1'b1;

   int total = 0;
   int bad = 0;

   alu_sequencer #(.DATA_W(8), .GNT_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
      .alu_ee(alu_ee), .alu_eo(alu_eo), .alu_carry(alu_carry),
      .bus_in(bus_in), .bus_req(bus_req), .bus_gnt(bus_gnt),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_err(res_err), .flag_z(flag_z), .flag_c(flag_c)
   );

   always #5 clk = ~clk;

   // ALU model: result/carry registered on alu_ee, bus shows it while alu_eo.
   logic [7:0] alu_res_m;
   logic       alu_c_m;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_res_m <= 8'h00;
         alu_c_m   <= 1'b0;
      end else if (alu_ee) begin
         case (alu_mode)
            3'b000:  {alu_c_m, alu_res_m} <= {1'b0, alu_a} + {1'b0, alu_b};
            3'b010:  begin alu_res_m <= alu_a - alu_b; alu_c_m <= (alu_a < alu_b); end
            3'b101:  begin alu_res_m <= alu_a & alu_b; alu_c_m <= 1'b0; end
            3'b110:  begin alu_res_m <= alu_a | alu_b; alu_c_m <= 1'b0; end
            3'b111:  begin alu_res_m <= alu_a ^ alu_b; alu_c_m <= 1'b0; end
            default: begin alu_res_m <= 8'hEE; alu_c_m <= 1'b1; end
         endcase
      end
   end
   assign alu_carry = alu_c_m;
   assign bus_in    = alu_eo ? alu_res_m : 8'hA5;
   assign bus_gnt   = gnt_en & bus_req;

   int         ee_cnt = 0;
   logic [7:0] first_b = 8'h00;
   logic [2:0] first_mode = 3'b000;
   logic       eo_seen = 1'b0;
   always @(negedge clk) begin
      if (alu_ee) begin
         if (ee_cnt == 0) begin
            first_b    = alu_b;
            first_mode = alu_mode;
         end
         ee_cnt++;
      end
      if (alu_eo) eo_seen = 1'b1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issue one command and return the cycle index at which res_valid appears.
   task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat);
      int w;
      w = 0;
      while (!cmd_ready && w < 50) begin
         @(posedge clk); #1; w++;
      end
      ee_cnt = 0;
      eo_seen = 1'b0;
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      lat = 1;
      while (!res_valid && lat < 100) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   typedef struct {
      logic [2:0] op;
      logic [7:0] a, b;
      logic [7:0] exp_data;
      logic       exp_z, exp_c;
      int         exp_lat, exp_ee;
      logic [7:0] exp_b;
      logic [2:0] exp_mode;
   } vec_t;

   vec_t vecs[13];

   initial begin
      int lat;
      int cnt_v;
      logic pz, pc;

      vecs[0]  = '{OP_ADD, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 4, 1, 8'h01, 3'b000};
      vecs[1]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 4, 1, 8'h01, 3'b000};
      vecs[2]  = '{OP_AND, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 4, 1, 8'h0F, 3'b101};
      vecs[3]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 4, 1, 8'h01, 3'b000};
      vecs[4]  = '{OP_ADC, 8'h10, 8'h20, 8'h31, 1'b0, 1'b0, 6, 2, 8'h20, 3'b000};
      vecs[5]  = '{OP_INC, 8'hFF, 8'hAA, 8'h00, 1'b1, 1'b1, 4, 1, 8'h01, 3'b000};
      vecs[6]  = '{OP_ADC, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 6, 2, 8'h00, 3'b000};
      vecs[7]  = '{OP_DEC, 8'h00, 8'h77, 8'hFF, 1'b0, 1'b1, 4, 1, 8'h01, 3'b010};
      vecs[8]  = '{OP_SUB, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 4, 1, 8'h03, 3'b010};
      vecs[9]  = '{OP_OR,  8'h12, 8'h34, 8'h36, 1'b0, 1'b0, 4, 1, 8'h34, 3'b110};
      vecs[10] = '{OP_SUB, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1, 4, 1, 8'h05, 3'b010};
      vecs[11] = '{OP_ADC, 8'h01, 8'h02, 8'h04, 1'b0, 1'b0, 6, 2, 8'h02, 3'b000};
      vecs[12] = '{OP_XOR, 8'h5A, 8'h5A, 8'h00, 1'b1, 1'b0, 4, 1, 8'h5A, 3'b111};

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_bus_req", bus_req, 0);
      check("rst_alu_eo", alu_eo, 0);
      check("rst_res_data", res_data, 0);
      check("rst_flags", {flag_z, flag_c}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("ready_after_rst", cmd_ready, 1);

      // Table-driven command vectors with immediate grant.
      for (int i = 0; i < 13; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         check($sformatf("v%0d_valid", i), res_valid, 1);
         check($sformatf("v%0d_data", i), res_data, vecs[i].exp_data);
         check($sformatf("v%0d_err", i), res_err, 0);
         check($sformatf("v%0d_z", i), flag_z, vecs[i].exp_z);
         check($sformatf("v%0d_c", i), flag_c, vecs[i].exp_c);
         check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
         check($sformatf("v%0d_ee", i), ee_cnt, vecs[i].exp_ee);
         check($sformatf("v%0d_alu_b", i), first_b, vecs[i].exp_b);
         check($sformatf("v%0d_mode", i), first_mode, vecs[i].exp_mode);
         @(posedge clk); #1;
         check($sformatf("v%0d_one_cycle", i), res_valid, 0);
         check($sformatf("v%0d_ready_back", i), cmd_ready, 1);
      end

      // Bus timeout with the consumer stalling for 3 cycles.
      pz = flag_z; pc = flag_c;
      gnt_en = 1'b0;
      res_ready = 1'b0;
      issue(OP_ADD, 8'h01, 8'h01, lat);
      check("to_valid", res_valid, 1);
      check("to_err", res_err, 1);
      check("to_data", res_data, 0);
      check("to_flags", {flag_z, flag_c}, {pz, pc});
      check("to_no_eo", eo_seen, 0);
      check("to_cmd_ready", cmd_ready, 0);
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         check($sformatf("to_hold%0d", k), res_valid, 1);
         check($sformatf("to_hold_err%0d", k), res_err, 1);
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      check("to_released", res_valid, 0);
      gnt_en = 1'b1;

      // Reset asserted while the result is being driven.
      issue_to_drive();
      rst = 1'b1;
      #1;
      check("rst_mid_eo", alu_eo, 0);
      check("rst_mid_req", bus_req, 0);
      @(negedge clk);
      check("rst_mid_flags", {flag_z, flag_c}, 0);
      check("rst_mid_valid", res_valid, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_mid_ready", cmd_ready, 1);
      check("rst_mid_flags2", {flag_z, flag_c}, 0);
      cnt_v = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (res_valid) cnt_v++;
      end
      check("rst_mid_no_resp", cnt_v, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   task automatic issue_to_drive();
      int w;
      w = 0;
      while (!cmd_ready && w < 50) begin
         @(posedge clk); #1; w++;
      end
      cmd_op = OP_ADD; cmd_a = 8'hFF; cmd_b = 8'h01; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      w = 0;
      while (!alu_eo && w < 50) begin
         @(posedge clk); #1; w++;
      end
      check("reach_drive", alu_eo, 1);
   endtask

endmodule
